// File: rtl/band_sample_queue.sv
// Decimating circular sample buffer that replays the newest TAPS samples,
// oldest first, to the band FIR MAC after every accepted write once full.
module band_sample_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int TAPS   = 1021,
  parameter int DECIM  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] new_smpl,
  input  logic              wrt_smpl,
  output logic [DATA_W-1:0] smpl_out,
  output logic              sequencing,
  output logic              ready,
  output logic              overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [AW-1:0] TAPS_A   = AW'(TAPS);
  localparam logic [CW-1:0] TAPS_C   = CW'(TAPS);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  // Handshake: wrt_smpl is a one-cycle strobe with no backpressure, and
  // smpl_out is valid exactly in the cycles where sequencing is high.
  typedef enum logic [1:0] {IDLE, PRIME, BURST} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     fill;
  logic [CW-1:0]     rd_cnt;
  logic [DW-1:0]     dec_cnt;
  logic              accept;
  logic              trigger;
  logic [CW-1:0]     fill_next;

  always_comb begin
    accept    = wrt_smpl && !clr && (dec_cnt == DEC_LAST);
    fill_next = (fill == TAPS_C) ? fill : fill + CW'(1);
    trigger   = accept && (state == IDLE) && (fill_next == TAPS_C);
  end

  assign ready = (fill == TAPS_C);

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_smpl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      fill    <= '0;
      dec_cnt <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      fill    <= '0;
      dec_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (wrt_smpl) dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DW'(1);
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        fill   <= fill_next;
        if (state != IDLE) overrun <= 1'b1;
      end
    end
  end

  // Window start is the oldest of the TAPS samples ending at the new write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      smpl_out   <= '0;
      sequencing <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      smpl_out   <= '0;
      sequencing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            rd_addr <= wr_ptr + AW'(1) - TAPS_A;
            state   <= PRIME;
          end
        end
        PRIME: begin
          smpl_out   <= mem[rd_addr];
          rd_addr    <= rd_addr + AW'(1);
          rd_cnt     <= CW'(1);
          sequencing <= 1'b1;
          state      <= BURST;
        end
        BURST: begin
          if (rd_cnt == TAPS_C) begin
            sequencing <= 1'b0;
            state      <= IDLE;
          end else begin
            smpl_out <= mem[rd_addr];
            rd_addr  <= rd_addr + AW'(1);
            rd_cnt   <= rd_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_band_sample_queue.sv
// Randomised and directed bench for band_sample_queue over three parameter
// sets, checked against a sample-list reference model and an expected queue.
module tb_band_sample_queue;

  localparam int P_TAPS  [3] = '{5, 5, 1021};
  localparam int P_DECIM [3] = '{2, 1, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       clr_v  = '0;
  logic [2:0]       wrt_v  = '0;
  logic [2:0][15:0] smpl_v = '0;
  logic [2:0][15:0] out_w;
  logic [2:0]       seq_w;
  logic [2:0]       rdy_w;
  logic [2:0]       ovr_w;

  band_sample_queue #(.DATA_W(16), .DEPTH(8), .TAPS(5), .DECIM(2)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .new_smpl(smpl_v[0]),
    .wrt_smpl(wrt_v[0]), .smpl_out(out_w[0]), .sequencing(seq_w[0]),
    .ready(rdy_w[0]), .overrun(ovr_w[0]));

  band_sample_queue #(.DATA_W(16), .DEPTH(8), .TAPS(5), .DECIM(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .new_smpl(smpl_v[1]),
    .wrt_smpl(wrt_v[1]), .smpl_out(out_w[1]), .sequencing(seq_w[1]),
    .ready(rdy_w[1]), .overrun(ovr_w[1]));

  band_sample_queue #(.DATA_W(16), .DEPTH(1024), .TAPS(1021), .DECIM(2)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .new_smpl(smpl_v[2]),
    .wrt_smpl(wrt_v[2]), .smpl_out(out_w[2]), .sequencing(seq_w[2]),
    .ready(rdy_w[2]), .overrun(ovr_w[2]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          m_fill [3];
  int          m_dec  [3];
  int          m_busy [3];
  logic        m_ovr  [3];
  logic [15:0] m_last [3];
  logic [15:0] hist      [3][$];
  logic [15:0] exp_q     [3][$];
  int          exp_cyc_q [3][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    m_fill[k] = 0;
    m_dec[k]  = 0;
    m_busy[k] = -1;
    m_ovr[k]  = 1'b0;
    m_last[k] = '0;
    hist[k].delete();
    exp_q[k].delete();
    exp_cyc_q[k].delete();
  endtask

  // A burst plays the newest TAPS accepted samples in cycles c+2..c+1+TAPS.
  task automatic model_edge(input int k, input int c);
    logic acc;
    logic busy;
    if (clr_v[k]) begin
      model_reset(k);
    end else if (wrt_v[k]) begin
      acc = (m_dec[k] == P_DECIM[k] - 1);
      m_dec[k] = acc ? 0 : m_dec[k] + 1;
      if (acc) begin
        busy = (c <= m_busy[k]);
        hist[k].push_back(smpl_v[k]);
        if (hist[k].size() > P_TAPS[k]) void'(hist[k].pop_front());
        if (busy) m_ovr[k] = 1'b1;
        if (m_fill[k] < P_TAPS[k]) m_fill[k]++;
        if (!busy && m_fill[k] == P_TAPS[k]) begin
          for (int i = 0; i < P_TAPS[k]; i++) begin
            exp_q[k].push_back(hist[k][i]);
            exp_cyc_q[k].push_back(c + 2 + i);
          end
          m_busy[k] = c + 1 + P_TAPS[k];
        end
      end
    end
  endtask

  task automatic step(input int k, input logic clr, input logic wrt, input logic [15:0] d);
    clr_v = '0;
    wrt_v = '0;
    clr_v[k] = clr;
    wrt_v[k] = wrt;
    smpl_v[k] = d;
    @(posedge clk);
    model_edge(k, cyc);
    cyc++;
    #1;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic mon(input int k);
    logic        exp_seq;
    logic [15:0] d;
    exp_seq = 1'b0;
    if (exp_cyc_q[k].size() > 0) exp_seq = (exp_cyc_q[k][0] == cyc);
    chk($sformatf("u%0d sequencing", k), 32'(seq_w[k]), 32'(exp_seq));
    chk($sformatf("u%0d ready", k), 32'(rdy_w[k]), 32'(m_fill[k] == P_TAPS[k]));
    chk($sformatf("u%0d overrun", k), 32'(ovr_w[k]), 32'(m_ovr[k]));
    if (exp_seq) begin
      d = exp_q[k].pop_front();
      void'(exp_cyc_q[k].pop_front());
      if (seq_w[k]) chk($sformatf("u%0d smpl_out", k), 32'(out_w[k]), 32'(d));
      m_last[k] = d;
    end else if (!seq_w[k]) begin
      chk($sformatf("u%0d smpl_out hold", k), 32'(out_w[k]), 32'(m_last[k]));
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  initial begin
    for (int k = 0; k < 3; k++) model_reset(k);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Decimated fill, first burst, then bursts across the pointer wrap.
    for (int v = 1; v <= 20; v++) begin
      step(0, 1'b0, 1'b1, 16'(v));
      idle(0, 3);
    end

    // Flush in the third burst cycle, then refill from empty.
    step(0, 1'b0, 1'b1, 16'h15);
    step(0, 1'b0, 1'b1, 16'h16);
    idle(0, 3);
    step(0, 1'b1, 1'b0, 16'h0);
    for (int v = 16'h30; v < 16'h3a; v++) begin
      step(0, 1'b0, 1'b1, 16'(v));
      idle(0, 1);
    end
    idle(0, 8);

    // Asynchronous reset in the middle of a burst.
    step(0, 1'b0, 1'b1, 16'h40);
    step(0, 1'b0, 1'b1, 16'h41);
    idle(0, 3);
    rst_n = 1'b0;
    #1;
    chk("async rst sequencing", 32'(seq_w[0]), 32'd0);
    chk("async rst smpl_out", 32'(out_w[0]), 32'd0);
    chk("async rst ready", 32'(rdy_w[0]), 32'd0);
    chk("async rst overrun", 32'(ovr_w[0]), 32'd0);
    for (int k = 0; k < 3; k++) model_reset(k);
    #1 rst_n = 1'b1;
    for (int v = 16'h50; v < 16'h5c; v++) begin
      step(0, 1'b0, 1'b1, 16'(v));
      idle(0, 3);
    end
    idle(0, 8);

    // DECIM=1: back-to-back strobes overrun the first burst.
    for (int v = 0; v < 7; v++) step(1, 1'b0, 1'b1, 16'(16'h100 + v));
    idle(1, 10);
    step(1, 1'b0, 1'b1, 16'h200);
    idle(1, 10);

    // Random traffic with occasional flushes on both small configurations.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 400; i++) begin
        int r;
        r = $urandom_range(0, 99);
        step(k, r < 2, r < 40, 16'($urandom));
      end
      idle(k, 10);
    end

    // Default parameters: one full-length burst.
    for (int i = 0; i < 2 * 1021; i++) step(2, 1'b0, 1'b1, 16'($urandom));
    idle(2, 1030);

    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d drained", k), 32'(exp_q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/band_sample_queue.md
Name: band_sample_queue

Overview:
- Parametrised circular sample queue for the equalizer band filters.
- Decimates the incoming sample stream by DECIM and stores accepted samples in a DEPTH-entry circular buffer.
- Once TAPS samples are held, every accepted write triggers a burst that streams the newest TAPS samples, oldest first, to the downstream FIR MAC.
- Adds a synchronous flush, a fill/ready indication and a sticky overrun flag.

Parameters:
- DATA_W, 16: sample width in bits.
- DEPTH, 1024: buffer entries; power of 2; DEPTH >= TAPS+1.
- TAPS, 1021: samples per burst (FIR tap count); 2 <= TAPS <= DEPTH-1.
- DECIM, 2: write decimation factor; 1 = accept every sample.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous flush.
- new_smpl  in  DATA_W  input sample; valid when wrt_smpl=1.
- wrt_smpl  in  1  one-cycle sample strobe.
- smpl_out  out  DATA_W  burst sample; valid when sequencing=1.
- sequencing  out  1  high for exactly TAPS consecutive cycles per burst.
- ready  out  1  fill count has reached TAPS.
- overrun  out  1  sticky; an accepted write arrived while a burst was in progress or pending.

Behaviour:
- Reset (async) and clr (sync, priority over all other inputs) produce: wr_ptr=0, fill=0, dec_cnt=0, state=IDLE, smpl_out=0, sequencing=0, ready=0, overrun=0. Memory contents are not cleared.
- Decimation:
  - dec_cnt counts 0..DECIM-1 on each wrt_smpl and wraps.
  - A write is accepted when wrt_smpl=1 and dec_cnt==DECIM-1. With DECIM=1, every strobe is accepted.
  - wrt_smpl with clr=1 is ignored.
- Accepted write:
  - mem[wr_ptr] <= new_smpl; wr_ptr <= wr_ptr+1 modulo DEPTH.
  - fill <= min(fill+1, TAPS), i.e. it saturates at TAPS. ready = (fill==TAPS).
- Burst trigger: an accepted write in state IDLE whose post-write fill equals TAPS.
  - The trigger latches start = (wr_ptr+1-TAPS) mod DEPTH, computed at DEPTH width.
- States:
  - IDLE: on trigger -> PRIME.
  - PRIME: 1 cycle; issue synchronous read at start -> BURST.
  - BURST: read address increments mod DEPTH each cycle; rd_cnt counts TAPS outputs; after the TAPS-th output -> IDLE.
- Timing: for a triggering write in cycle N:
  - Memory write commits at the N edge.
  - PRIME runs in N+1.
  - sequencing=1 in cycles N+2..N+1+TAPS, with smpl_out = oldest..newest of the window.
  - Outside bursts, smpl_out holds its last value.
- Write during PRIME/BURST:
  - The sample is stored and the pointer/fill update as normal. Because DEPTH >= TAPS+1, the active window is never overwritten.
  - No new burst is started, and overrun is set to 1 (sticky until reset/clr).
- Back-to-back: the next trigger is legal from the cycle the state returns to IDLE.
- Read-before-write hazard: none, since a burst never reads the address written in the same cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH throughout. A burst window that spans address DEPTH-1 -> 0 must stream seamlessly.
- clr mid-burst: sequencing drops to 0 the next cycle and the burst is aborted.
- rst_n mid-burst: outputs drop immediately (asynchronous).

Test Plan:
1. DEPTH=8, TAPS=5, DECIM=2; strobe 0x0001..0x000A one per 4 cycles -> writes accepted for 2,4,6,8,0xA only. ready rises after 0xA; sequencing rises 2 cycles after that write and stays high 5 cycles; smpl_out = 2,4,6,8,0xA.
2. Same config, continue with 0x000B..0x0014 -> one burst per accepted write. Burst after 0xC gives 4,6,8,0xA,0xC. Bursts across the wr_ptr 7->0 wrap stream correctly, e.g. the burst after 0x14 gives 0xC,0xE,0x10,0x12,0x14.
3. DECIM=1, TAPS=5; strobe on consecutive cycles -> the 6th and 7th accepted writes land during PRIME/BURST; overrun=1 and stays set. The next accepted write after the return to IDLE starts a burst containing the latest 5 samples.
4. Assert clr in the 3rd cycle of a burst -> sequencing=0 the next cycle; ready=0, overrun=0; the following 4 accepted writes give no burst and the 5th triggers one.
5. Pulse rst_n low mid-burst -> outputs go to 0 asynchronously; after release, fill=0 and dec_cnt=0 (the first strobe is not accepted when DECIM=2).
6. Default parameters; 1021 decimated writes -> burst of exactly 1021 sequencing cycles, in order, with no gaps.
